// File: rtl/ror_pkg.sv
// Shared defaults and sequencer state encoding for the radius-outlier-removal batch sequencer.
package ror_pkg;

  localparam int unsigned DEF_N                = 16;
  localparam int unsigned DEF_CORE_NUMBER      = 64;
  localparam int unsigned DEF_DISTANCE_MODULES = 2;
  localparam int unsigned DEF_PIPE_LAT         = 4;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_SWEEP = 3'd2,
    ST_WAIT  = 3'd3,
    ST_SCAN  = 3'd4,
    ST_DONE  = 3'd5
  } state_t;

endpackage

// File: rtl/ror_outlier_scan.sv
// Captures the per-core outlier flags once per batch and walks them in ascending order,
// pushing in-range outlier indices into the FIFO and holding position while it is full.
module ror_outlier_scan #(
  parameter int unsigned W           = 32,
  parameter int unsigned CORE_NUMBER = 64
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   scan_en,
  input  logic                   capture,
  input  logic [CORE_NUMBER-1:0] core_outlier,
  input  logic [W-1:0]           point_pos,
  input  logic [W-1:0]           size,
  input  logic                   fifo_full,
  output logic                   fifo_wr_en,
  output logic [W-1:0]           fifo_wr_data,
  output logic                   scan_done
);

  localparam int unsigned KW = (CORE_NUMBER > 1) ? $clog2(CORE_NUMBER) : 1;

  logic [CORE_NUMBER-1:0] flags_q, flags_d;
  logic [KW-1:0]          k_q, k_d;
  logic [W-1:0]           idx;
  logic                   want, stall, last_k;

  always_comb begin
    idx          = point_pos + W'(k_q);
    want         = scan_en && flags_q[k_q] && (idx < size);
    stall        = want && fifo_full;
    last_k       = (k_q == KW'(CORE_NUMBER - 1));
    fifo_wr_en   = want && !fifo_full;
    fifo_wr_data = fifo_wr_en ? idx : '0;
    scan_done    = scan_en && !stall && last_k;
  end

  always_comb begin
    flags_d = flags_q;
    k_d     = k_q;
    if (capture) begin
      flags_d = core_outlier;
      k_d     = '0;
    end else if (scan_en && !stall) begin
      k_d = last_k ? '0 : k_q + KW'(1);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      flags_q <= '0;
      k_q     <= '0;
    end else begin
      flags_q <= flags_d;
      k_q     <= k_d;
    end
  end

endmodule

// File: rtl/ror_batch_sequencer.sv
// Batch sequencer: loads CORE_NUMBER distance cores, sweeps the whole cloud past them,
// waits out the core pipeline, then scans the captured outlier flags into the FIFO.
module ror_batch_sequencer
  import ror_pkg::*;
#(
  parameter int unsigned N                = DEF_N,
  parameter int unsigned CORE_NUMBER      = DEF_CORE_NUMBER,
  parameter int unsigned DISTANCE_MODULES = DEF_DISTANCE_MODULES,
  parameter int unsigned PIPE_LAT         = DEF_PIPE_LAT
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        start,
  input  logic [2*N-1:0]              point_cloud_size,
  input  logic [CORE_NUMBER-1:0]      core_outlier,
  input  logic                        fifo_full,
  output logic [2*N-1:0]              point_pos,
  output logic                        core_load,
  output logic [2*N-1:0]              feeder_pos,
  output logic                        feeder_valid,
  output logic [DISTANCE_MODULES-1:0] feeder_lane_valid,
  output logic                        feeder_last,
  output logic                        fifo_wr_en,
  output logic [2*N-1:0]              fifo_wr_data,
  output logic                        busy,
  output logic                        done
);

  localparam int unsigned W     = 2 * N;
  localparam int unsigned M     = DISTANCE_MODULES;
  localparam int unsigned LAT_W = $clog2(PIPE_LAT + 2);

  state_t           state_q, state_d;
  logic [W-1:0]     size_q, size_d;
  logic [W-1:0]     point_pos_q, point_pos_d;
  logic [W-1:0]     feeder_pos_q, feeder_pos_d;
  logic [LAT_W-1:0] lat_q, lat_d;
  logic [W-1:0]     next_pos;
  logic             sweep_last, capture, scan_en, scan_done;

  always_comb begin
    sweep_last = (feeder_pos_q + W'(M)) >= size_q;
    capture    = (state_q == ST_WAIT) && (lat_q >= LAT_W'(PIPE_LAT));
    scan_en    = (state_q == ST_SCAN);
    next_pos   = point_pos_q + W'(CORE_NUMBER);
  end

  always_comb begin
    state_d      = state_q;
    size_d       = size_q;
    point_pos_d  = point_pos_q;
    feeder_pos_d = feeder_pos_q;
    lat_d        = lat_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          size_d      = point_cloud_size;
          point_pos_d = '0;
          state_d     = (point_cloud_size == '0) ? ST_DONE : ST_LOAD;
        end
      end
      ST_LOAD: begin
        feeder_pos_d = '0;
        state_d      = ST_SWEEP;
      end
      ST_SWEEP: begin
        // Feeder position parks at zero outside SWEEP so it reads 0 in LOAD/idle.
        if (sweep_last) begin
          feeder_pos_d = '0;
          lat_d        = LAT_W'(1);
          state_d      = ST_WAIT;
        end else begin
          feeder_pos_d = feeder_pos_q + W'(M);
        end
      end
      ST_WAIT: begin
        if (capture) begin
          lat_d   = '0;
          state_d = ST_SCAN;
        end else begin
          lat_d = lat_q + LAT_W'(1);
        end
      end
      ST_SCAN: begin
        if (scan_done) begin
          point_pos_d = next_pos;
          state_d     = (next_pos >= size_q) ? ST_DONE : ST_LOAD;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      size_q       <= '0;
      point_pos_q  <= '0;
      feeder_pos_q <= '0;
      lat_q        <= '0;
    end else begin
      state_q      <= state_d;
      size_q       <= size_d;
      point_pos_q  <= point_pos_d;
      feeder_pos_q <= feeder_pos_d;
      lat_q        <= lat_d;
    end
  end

  always_comb begin
    point_pos         = point_pos_q;
    feeder_pos        = feeder_pos_q;
    core_load         = (state_q == ST_LOAD);
    feeder_valid      = (state_q == ST_SWEEP);
    feeder_last       = feeder_valid && sweep_last;
    busy              = (state_q != ST_IDLE) && (state_q != ST_DONE);
    done              = (state_q == ST_DONE);
    feeder_lane_valid = '0;
    for (int unsigned j = 0; j < M; j++) begin
      feeder_lane_valid[j] = feeder_valid && ((feeder_pos_q + W'(j)) < size_q);
    end
  end

  ror_outlier_scan #(
    .W           (W),
    .CORE_NUMBER (CORE_NUMBER)
  ) u_scan (
    .clock        (clock),
    .reset        (reset),
    .scan_en      (scan_en),
    .capture      (capture),
    .core_outlier (core_outlier),
    .point_pos    (point_pos_q),
    .size         (size_q),
    .fifo_full    (fifo_full),
    .fifo_wr_en   (fifo_wr_en),
    .fifo_wr_data (fifo_wr_data),
    .scan_done    (scan_done)
  );

endmodule

// File: tb/tb_ror_batch_sequencer.sv
// Directed bench for ror_batch_sequencer with CORE_NUMBER=4, M=2, PIPE_LAT=4.
module tb_ror_batch_sequencer;

  localparam int unsigned N  = 16;
  localparam int unsigned C  = 4;
  localparam int unsigned M  = 2;
  localparam int unsigned PL = 4;
  localparam int unsigned W  = 2 * N;

  logic           clock = 1'b0;
  logic           reset, start, fifo_full;
  logic [W-1:0]   point_cloud_size;
  logic [C-1:0]   core_outlier;
  logic [W-1:0]   point_pos, feeder_pos, fifo_wr_data;
  logic           core_load, feeder_valid, feeder_last, fifo_wr_en, busy, done;
  logic [M-1:0]   feeder_lane_valid;

  int vec_cnt = 0;
  int err_cnt = 0;

  int           n_loads, n_beats, n_lasts, n_cyc, wr_while_full;
  bit           timed_out;
  logic [W-1:0] last_pos, first_load_pos;
  logic [M-1:0] last_lanes;
  logic [W-1:0] wr_q[$];
  logic [W-1:0] exp_q[$];

  ror_batch_sequencer #(
    .N                (N),
    .CORE_NUMBER      (C),
    .DISTANCE_MODULES (M),
    .PIPE_LAT         (PL)
  ) dut (
    .clock             (clock),
    .reset             (reset),
    .start             (start),
    .point_cloud_size  (point_cloud_size),
    .core_outlier      (core_outlier),
    .fifo_full         (fifo_full),
    .point_pos         (point_pos),
    .core_load         (core_load),
    .feeder_pos        (feeder_pos),
    .feeder_valid      (feeder_valid),
    .feeder_lane_valid (feeder_lane_valid),
    .feeder_last       (feeder_last),
    .fifo_wr_en        (fifo_wr_en),
    .fifo_wr_data      (fifo_wr_data),
    .busy              (busy),
    .done              (done)
  );

  always #5 clock = ~clock;

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  // Starts a pass and records what the DUT does until done (bounded).
  task automatic run_pass(input logic [W-1:0] size, input logic [C-1:0] flags,
                          input int stall_len, input int poke_cyc);
    int lastc;
    bit have_last;
    n_loads = 0; n_beats = 0; n_lasts = 0; n_cyc = 0; wr_while_full = 0;
    last_pos = '0; last_lanes = '0; first_load_pos = '1;
    wr_q.delete();
    have_last = 0; lastc = 0; timed_out = 1;
    core_outlier = flags;
    point_cloud_size = size;
    start = 1'b1;
    tick();
    start = 1'b0;
    point_cloud_size = '0;
    for (int c = 0; c < 2000; c++) begin
      fifo_full = (stall_len > 0) && have_last && (c > lastc) && (c <= lastc + PL + 1 + stall_len);
      start = (c == poke_cyc);
      if (start) point_cloud_size = 100;
      #1;
      if (done) begin
        timed_out = 0;
        n_cyc = c;
        break;
      end
      if (core_load) begin
        if (n_loads == 0) first_load_pos = point_pos;
        n_loads++;
      end
      if (feeder_valid) n_beats++;
      if (feeder_last) begin
        n_lasts++;
        last_pos = feeder_pos;
        last_lanes = feeder_lane_valid;
        if (!have_last) begin
          have_last = 1;
          lastc = c;
        end
      end
      if (fifo_wr_en) begin
        wr_q.push_back(fifo_wr_data);
        if (fifo_full) wr_while_full++;
      end
      @(posedge clock);
      #1;
    end
    start = 1'b0;
    fifo_full = 1'b0;
    point_cloud_size = '0;
  endtask

  task automatic test_reset;
    reset = 1'b1; start = 1'b0; fifo_full = 1'b0;
    point_cloud_size = '0; core_outlier = '0;
    tick(); tick();
    vec_cnt++;
    if ({busy, done, core_load, feeder_valid, feeder_last, fifo_wr_en, feeder_lane_valid} !== '0) begin
      err_cnt++;
      $display("FAIL reset_ctrl: got %b expected 0",
               {busy, done, core_load, feeder_valid, feeder_last, fifo_wr_en, feeder_lane_valid});
    end
    vec_cnt++;
    if ({point_pos, feeder_pos, fifo_wr_data} !== '0) begin
      err_cnt++;
      $display("FAIL reset_data: got %h/%h/%h expected 0", point_pos, feeder_pos, fifo_wr_data);
    end
    reset = 1'b0;
    tick(); tick(); tick();
    vec_cnt++;
    if ({busy, done, core_load, feeder_valid, fifo_wr_en} !== '0) begin
      err_cnt++;
      $display("FAIL idle_no_activity: got %b expected 0", {busy, done, core_load, feeder_valid, fifo_wr_en});
    end
  endtask

  task automatic test_three_batches;
    run_pass(10, 4'b0000, 0, -1);
    vec_cnt++;
    if (timed_out) begin err_cnt++; $display("FAIL b3_done: got timeout expected done"); end
    vec_cnt++;
    if (n_loads !== 3) begin err_cnt++; $display("FAIL b3_loads: got %0d expected 3", n_loads); end
    vec_cnt++;
    if (n_beats !== 15) begin err_cnt++; $display("FAIL b3_beats: got %0d expected 15", n_beats); end
    vec_cnt++;
    if (n_lasts !== 3) begin err_cnt++; $display("FAIL b3_lasts: got %0d expected 3", n_lasts); end
    vec_cnt++;
    if (wr_q.size() !== 0) begin err_cnt++; $display("FAIL b3_writes: got %0d expected 0", wr_q.size()); end
    vec_cnt++;
    if (busy !== 1'b0) begin err_cnt++; $display("FAIL b3_busy_done: got %b expected 0", busy); end
  endtask

  task automatic test_lane_mask;
    run_pass(7, 4'b0000, 0, -1);
    vec_cnt++;
    if (last_pos !== 6) begin err_cnt++; $display("FAIL mask_pos: got %0d expected 6", last_pos); end
    vec_cnt++;
    if (last_lanes !== 2'b01) begin err_cnt++; $display("FAIL mask_lanes: got %b expected 01", last_lanes); end
    vec_cnt++;
    if (n_beats !== 8 || n_lasts !== 2) begin
      err_cnt++;
      $display("FAIL mask_beats: got %0d/%0d expected 8/2", n_beats, n_lasts);
    end
  endtask

  task automatic test_partial_batch;
    run_pass(6, 4'b1111, 0, -1);
    exp_q = '{0, 1, 2, 3, 4, 5};
    vec_cnt++;
    if (timed_out || n_loads !== 2) begin
      err_cnt++;
      $display("FAIL part_loads: got %0d (timeout=%0d) expected 2", n_loads, timed_out);
    end
    vec_cnt++;
    if (wr_q.size() !== exp_q.size()) begin
      err_cnt++;
      $display("FAIL part_count: got %0d expected %0d", wr_q.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        vec_cnt++;
        if (wr_q[i] !== exp_q[i]) begin
          err_cnt++;
          $display("FAIL part_data[%0d]: got %0d expected %0d", i, wr_q[i], exp_q[i]);
        end
      end
    end
  endtask

  task automatic test_fifo_stall;
    run_pass(4, 4'b1010, 3, -1);
    exp_q = '{1, 3};
    vec_cnt++;
    if (timed_out) begin err_cnt++; $display("FAIL stall_done: got timeout expected done"); end
    vec_cnt++;
    if (wr_while_full !== 0) begin
      err_cnt++;
      $display("FAIL stall_wr_full: got %0d expected 0", wr_while_full);
    end
    vec_cnt++;
    if (wr_q.size() !== exp_q.size()) begin
      err_cnt++;
      $display("FAIL stall_count: got %0d expected %0d", wr_q.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        vec_cnt++;
        if (wr_q[i] !== exp_q[i]) begin
          err_cnt++;
          $display("FAIL stall_data[%0d]: got %0d expected %0d", i, wr_q[i], exp_q[i]);
        end
      end
    end
  endtask

  task automatic test_start_ignored;
    run_pass(10, 4'b0000, 0, 3);
    vec_cnt++;
    if (timed_out || n_loads !== 3 || n_beats !== 15) begin
      err_cnt++;
      $display("FAIL busy_start: got loads %0d beats %0d expected 3/15", n_loads, n_beats);
    end
  endtask

  task automatic test_back_to_back;
    bit seen;
    core_outlier = '0;
    point_cloud_size = 4;
    start = 1'b1;
    tick();
    start = 1'b0;
    vec_cnt++;
    if ({done, busy, core_load} !== 3'b011) begin
      err_cnt++;
      $display("FAIL restart: got done/busy/load %b expected 011", {done, busy, core_load});
    end
    seen = 0;
    for (int c = 0; c < 200; c++) begin
      if (done) begin seen = 1; break; end
      tick();
    end
    vec_cnt++;
    if (!seen) begin err_cnt++; $display("FAIL restart_done: got timeout expected done"); end
  endtask

  task automatic test_reset_in_scan;
    bit seen;
    core_outlier = 4'b1111;
    point_cloud_size = 10;
    start = 1'b1;
    tick();
    start = 1'b0;
    seen = 0;
    for (int c = 0; c < 200; c++) begin
      #1;
      if (fifo_wr_en) begin seen = 1; break; end
      @(posedge clock);
      #1;
    end
    vec_cnt++;
    if (!seen) begin err_cnt++; $display("FAIL rst_scan_reach: got no write expected write"); end
    #1 reset = 1'b1;
    #1;
    vec_cnt++;
    if ({busy, done, core_load, feeder_valid, fifo_wr_en} !== '0 || {point_pos, fifo_wr_data} !== '0) begin
      err_cnt++;
      $display("FAIL rst_scan_outputs: got %b/%h/%h expected 0",
               {busy, done, core_load, feeder_valid, fifo_wr_en}, point_pos, fifo_wr_data);
    end
    tick();
    reset = 1'b0;
    core_outlier = '0;
    tick(); tick();
    vec_cnt++;
    if ({busy, fifo_wr_en, core_load} !== '0) begin
      err_cnt++;
      $display("FAIL rst_scan_quiet: got %b expected 0", {busy, fifo_wr_en, core_load});
    end
    run_pass(5, 4'b1111, 0, -1);
    vec_cnt++;
    if (first_load_pos !== 0) begin
      err_cnt++;
      $display("FAIL rst_fresh_pos: got %0d expected 0", first_load_pos);
    end
    vec_cnt++;
    if (timed_out || wr_q.size() !== 5 || wr_q[0] !== 0 || wr_q[4] !== 4) begin
      err_cnt++;
      $display("FAIL rst_fresh_writes: got %0d writes expected 5 (0..4)", wr_q.size());
    end
  endtask

  task automatic test_zero_size;
    run_pass(0, 4'b1111, 0, -1);
    vec_cnt++;
    if (timed_out || n_cyc !== 0) begin
      err_cnt++;
      $display("FAIL zero_done: got cycle %0d (timeout=%0d) expected 0", n_cyc, timed_out);
    end
    vec_cnt++;
    if (n_loads !== 0 || n_beats !== 0 || wr_q.size() !== 0) begin
      err_cnt++;
      $display("FAIL zero_activity: got loads %0d beats %0d writes %0d expected 0",
               n_loads, n_beats, wr_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_three_batches();
    test_lane_mask();
    test_partial_batch();
    test_fifo_stall();
    test_start_ignored();
    test_back_to_back();
    test_reset_in_scan();
    test_zero_size();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
